// File: rtl/input_fifo_pkg.sv
// Shared NoC package: flit width and FIFO depth defaults, the flit type, and
// the output-port arbiter's Xbar_sel one-hot encodings.
package input_fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 32;
  localparam int FIFO_DEPTH      = 4;

  typedef logic [FIFO_DATA_WIDTH-1:0] flit_t;

  // Xbar_sel one-hot codes, one bit per output port.
  localparam logic [4:0] XBAR_SEL_N = 5'b00001;
  localparam logic [4:0] XBAR_SEL_E = 5'b00010;
  localparam logic [4:0] XBAR_SEL_W = 5'b00100;
  localparam logic [4:0] XBAR_SEL_S = 5'b01000;
  localparam logic [4:0] XBAR_SEL_L = 5'b10000;

endpackage

// File: rtl/input_fifo.sv
// Router input FIFO with a DRTS/CTS handshake on the write side and
// first-word-fall-through reads driven by the output-port arbiters.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   RX                 flit from the upstream router
//   DRTS               upstream request-to-send (held until CTS seen)
//   read_en_N/E/W/S/L  pop requests from the five output arbiters
//   CTS                registered clear-to-send pulse to upstream
//   Data_out           head flit (zero when empty), combinational
//   empty_out          occupancy is zero
//
// Handshake: upstream raises DRTS with RX valid and holds both until it sees
// CTS=1. A flit is accepted in the cycle where DRTS=1, CTS=0 and the FIFO is
// not full; CTS is high for exactly the following cycle, which also blocks a
// second accept of the same held request. On the read side, any read_en high
// while not empty pops exactly one flit at the next edge.
module input_fifo
  import input_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  DRTS,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic                  CTS,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty_out
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;

  logic full;
  logic wr;
  logic rd;

  assign full      = (count == FULL_COUNT);
  assign empty_out = (count == '0);

  // CTS in the condition stops a held DRTS from writing the same flit twice.
  assign wr = DRTS & ~CTS & ~full;
  assign rd = (read_en_N | read_en_E | read_en_W | read_en_S | read_en_L) & ~empty_out;

  assign Data_out = empty_out ? '0 : mem[rd_ptr];

  // Storage is written only outside reset and is never cleared; stale
  // contents are hidden because Data_out is forced to zero when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      CTS    <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      CTS <= wr;
      if (wr) begin
        mem[wr_ptr] <= RX;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_input_fifo.sv
// Testbench for input_fifo: directed vectors, expected flits queued by the
// drivers and checked by an independent pop monitor.
module tb_input_fifo;
  import input_fifo_pkg::*;

  localparam int W = FIFO_DATA_WIDTH;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  flit_t  RX;
  logic   DRTS;
  logic   read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
  logic   CTS;
  flit_t  Data_out;
  logic   empty_out;

  always #5 clk = ~clk;

  input_fifo #(.DATA_WIDTH(W), .DEPTH(FIFO_DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .DRTS      (DRTS),
    .read_en_N (read_en_N),
    .read_en_E (read_en_E),
    .read_en_W (read_en_W),
    .read_en_S (read_en_S),
    .read_en_L (read_en_L),
    .CTS       (CTS),
    .Data_out  (Data_out),
    .empty_out (empty_out)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_rd(input logic [4:0] sel);
    read_en_N = (sel & XBAR_SEL_N) != 5'b0;
    read_en_E = (sel & XBAR_SEL_E) != 5'b0;
    read_en_W = (sel & XBAR_SEL_W) != 5'b0;
    read_en_S = (sel & XBAR_SEL_S) != 5'b0;
    read_en_L = (sel & XBAR_SEL_L) != 5'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; DRTS = 1'b0; RX = '0; set_rd(5'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask

  // Issue one DRTS request and hold it until CTS is seen (bounded).
  task automatic send(input logic [W-1:0] d);
    logic got;
    exp_q.push_back(d);
    @(posedge clk); #1;
    DRTS = 1'b1; RX = d;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (CTS) begin got = 1'b1; break; end
    end
    chk("cts_handshake", W'(got), W'(1));
    @(posedge clk); #1 DRTS = 1'b0;
  endtask

  // Hold the given read enables for n cycles.
  task automatic pop_n(input logic [4:0] sel, input int n);
    @(posedge clk); #1 set_rd(sel);
    repeat (n) @(posedge clk);
    #1 set_rd(5'b0);
  endtask

  // Write and read in the same cycle at occupancy 2.
  task automatic simul(input logic [W-1:0] d, input logic [W-1:0] next_head);
    exp_q.push_back(d);
    @(posedge clk); #1;
    DRTS = 1'b1; RX = d; set_rd(XBAR_SEL_W);
    @(posedge clk); #1 set_rd(5'b0);
    @(negedge clk);
    chk("simul_cts", W'(CTS), W'(1));
    chk("simul_head", Data_out, next_head);
    chk("simul_nonempty", W'(empty_out), W'(0));
    @(posedge clk); #1 DRTS = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !empty_out &&
          (read_en_N | read_en_E | read_en_W | read_en_S | read_en_L)) begin
        if (exp_q.size() == 0) chk("pop_unexpected", Data_out, '0);
        else chk("pop_data", Data_out, exp_q.pop_front());
      end
    end
  end

  // Watchdog against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic seen;
    rst = 1'b1; DRTS = 1'b0; RX = '0; set_rd(5'b0);
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_empty", W'(empty_out), W'(1));
    chk("rst_data", Data_out, '0);
    chk("rst_cts", W'(CTS), W'(0));

    // Single handshake with 0xA5A5A5A5
    exp_q.push_back(32'hA5A5_A5A5);
    @(posedge clk); #1 DRTS = 1'b1; RX = 32'hA5A5_A5A5;
    @(negedge clk);
    chk("hs_cts_t", W'(CTS), W'(0));
    @(negedge clk);
    chk("hs_cts_t1", W'(CTS), W'(1));
    chk("hs_empty_t1", W'(empty_out), W'(0));
    chk("hs_data_t1", Data_out, 32'hA5A5_A5A5);
    @(posedge clk); #1 DRTS = 1'b0;
    @(negedge clk);
    chk("hs_cts_t2", W'(CTS), W'(0));
    pop_n(XBAR_SEL_W, 1);
    @(negedge clk);
    chk("hs_drained", W'(empty_out), W'(1));

    // Fill to full, stall the fifth request, release with read_en_L
    for (int i = 1; i <= 4; i++) send(W'(i));
    fork
      send(32'd5);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("full_stall_cts", W'(CTS), W'(0));
        end
        @(posedge clk); #1 set_rd(XBAR_SEL_L);
        @(posedge clk); #1 set_rd(5'b0);
        seen = 1'b0;
        repeat (2) begin
          @(negedge clk);
          if (CTS) seen = 1'b1;
        end
        chk("full_release_cts", W'(seen), W'(1));
      end
    join
    pop_n(XBAR_SEL_N, 4);
    @(negedge clk);
    chk("full_drained", W'(empty_out), W'(1));

    // Two read enables together pop exactly one flit
    send(32'd1);
    send(32'd2);
    pop_n(XBAR_SEL_N | XBAR_SEL_S, 1);
    @(negedge clk);
    chk("multi_rd_head", Data_out, 32'd2);
    chk("multi_rd_nonempty", W'(empty_out), W'(0));
    pop_n(XBAR_SEL_E, 1);
    @(negedge clk);
    chk("multi_rd_occ1", W'(empty_out), W'(1));

    // Simultaneous write/read at occupancy 2, six flits through (wraps)
    send(32'h10);
    send(32'h11);
    simul(32'h12, 32'h11);
    simul(32'h13, 32'h12);
    simul(32'h14, 32'h13);
    simul(32'h15, 32'h14);
    pop_n(XBAR_SEL_S, 1);
    @(negedge clk);
    chk("simul_occ_last", W'(empty_out), W'(0));
    chk("simul_last_head", Data_out, 32'h15);
    pop_n(XBAR_SEL_S, 1);
    @(negedge clk);
    chk("simul_drained", W'(empty_out), W'(1));

    // read_en while empty is ignored
    @(posedge clk); #1 set_rd(XBAR_SEL_E);
    repeat (3) begin
      @(negedge clk);
      chk("empty_rd_empty", W'(empty_out), W'(1));
      chk("empty_rd_data", Data_out, '0);
    end
    @(posedge clk); #1 set_rd(5'b0);
    send(32'h77);
    @(negedge clk);
    chk("empty_rd_then_write", Data_out, 32'h77);
    pop_n(XBAR_SEL_L, 1);

    // Reset with occupancy 3 and a pending DRTS
    send(32'h31);
    send(32'h32);
    send(32'h33);
    @(posedge clk); #1 rst = 1'b1; DRTS = 1'b1; RX = 32'h34;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h34);
    @(negedge clk);
    chk("midrst_empty", W'(empty_out), W'(1));
    chk("midrst_cts", W'(CTS), W'(0));
    chk("midrst_data", Data_out, '0);
    @(negedge clk);
    chk("midrst_new_cts", W'(CTS), W'(1));
    chk("midrst_new_data", Data_out, 32'h34);
    @(posedge clk); #1 DRTS = 1'b0;
    pop_n(XBAR_SEL_N, 1);
    @(negedge clk);
    chk("midrst_drained", W'(empty_out), W'(1));

    repeat (2) @(negedge clk);
    chk("scoreboard_left", W'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
